uart_rx_fsm: RTL and testbench

UART receive path: the counterpart of the team's UART transmitter. It synchronises the serial line and detects the start bit with 16x oversampling. It samples each data bit at mid-bit, LSB first, with optional parity, checks the stop bit, and presents the received word with ready and error flags to the host side.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_sample_tick.sv | 32 +++
 rtl/uart_rx_fsm.sv | 167 ++++++++++++++++
 tb/tb_uart_rx_fsm.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants,
// common to the receiver and the transmitter so both agree on the bit period.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int         OVERSAMPLE  = 16;
    localparam logic [3:0] MID_SAMPLE  = 4'd7;
    localparam logic [3:0] LAST_SAMPLE = 4'd15;

endpackage

// File: rtl/uart_sample_tick.sv
// Oversample tick divider: one-cycle tick every CLKS_PER_SAMPLE enabled clocks,
// with a synchronous clear that restarts the count phase.
module uart_sample_tick #(
    parameter int CLKS_PER_SAMPLE = 13
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_SAMPLE - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == TERMINAL) ? '0 : count + 1'b1;
        end
    end

    assign tick = enable && !clear && (count == TERMINAL);

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver: 2-flop line synchroniser, 16x oversampled start detection,
// mid-bit data/parity/stop sampling and a sticky host-side status interface.
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int WORD_LENGTH     = 8,
    parameter int CLKS_PER_SAMPLE = 13,
    parameter int PARITY_EN       = 0,
    parameter int PARITY_ODD      = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   serial_in,
    input  logic                   clear_ready,
    output logic [WORD_LENGTH-1:0] rx_data,
    output logic                   rx_ready,
    output logic                   parity_error,
    output logic                   framing_error,
    output logic                   overrun,
    output logic                   busy
);

    localparam int                SAMPLE_W = $clog2(OVERSAMPLE);
    localparam int                BIT_W    = $clog2(WORD_LENGTH);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(WORD_LENGTH - 1);
    localparam logic              PAR_ODD  = (PARITY_ODD != 0);

    uart_state_t          state, state_next;
    logic                 sync_meta, rx_s;
    logic [1:0]           sync_valid;
    logic                 armed;
    logic                 tick;
    logic [SAMPLE_W-1:0]  sample_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [WORD_LENGTH-1:0] shift_reg;
    logic                 par_bit;
    logic                 parity_fail;

    logic clr_tick, clr_sample, clr_bits, shift_en, par_en, complete;

    // Synchroniser resets high; armed only rises once the flushed line is seen
    // high, so a line held low through reset release cannot fake a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta  <= 1'b1;
            rx_s       <= 1'b1;
            sync_valid <= 2'b00;
            armed      <= 1'b0;
        end else begin
            sync_meta  <= serial_in;
            rx_s       <= sync_meta;
            sync_valid <= {sync_valid[0], 1'b1};
            if (sync_valid[1] && rx_s) armed <= 1'b1;
        end
    end

    assign busy = (state != IDLE);

    uart_sample_tick #(
        .CLKS_PER_SAMPLE(CLKS_PER_SAMPLE)
    ) u_sample_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (busy),
        .clear  (clr_tick),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every always_comb output gets a default before the case so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        clr_tick   = 1'b0;
        clr_sample = 1'b0;
        clr_bits   = 1'b0;
        shift_en   = 1'b0;
        par_en     = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (armed && !rx_s) begin
                    state_next = START;
                    clr_tick   = 1'b1;
                    clr_sample = 1'b1;
                end
            end
            START: begin
                if (tick && sample_cnt == MID_SAMPLE) begin
                    if (rx_s) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                        clr_sample = 1'b1;
                        clr_bits   = 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick && sample_cnt == LAST_SAMPLE) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT)
                        state_next = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (tick && sample_cnt == LAST_SAMPLE) begin
                    par_en     = 1'b1;
                    state_next = STOP;
                end
            end
            STOP: begin
                // Leaving at mid stop bit gives half a bit of slack for the next start edge.
                if (tick && sample_cnt == LAST_SAMPLE) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign parity_fail = (PARITY_EN != 0) && ((^shift_reg ^ par_bit) != PAR_ODD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_bit    <= 1'b0;
        end else begin
            if (clr_sample)  sample_cnt <= '0;
            else if (tick)   sample_cnt <= sample_cnt + 1'b1;

            if (clr_bits)      bit_cnt <= '0;
            else if (shift_en) bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;

            if (shift_en) shift_reg <= {rx_s, shift_reg[WORD_LENGTH-1:1]};
            if (par_en)   par_bit   <= rx_s;
        end
    end

    // Frame completion takes priority over a simultaneous host acknowledge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data       <= '0;
            rx_ready      <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else if (complete) begin
            rx_data       <= shift_reg;
            framing_error <= ~rx_s;
            parity_error  <= parity_fail;
            rx_ready      <= 1'b1;
            overrun       <= rx_ready & ~clear_ready;
        end else if (clear_ready) begin
            rx_ready <= 1'b0;
            overrun  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed plus randomized bench for uart_rx_fsm: an 8N1 instance and an 8E1
// instance, each compared against a frame-level model of the receiver.
module tb_uart_rx_fsm;

    localparam int CPS = 13;
    localparam int BIT = 16 * CPS;

    logic       clk = 1'b0;
    logic       reset;
    logic       serial_in_a, serial_in_b;
    logic       clear_a, clear_b;
    logic [7:0] rx_data_a, rx_data_b;
    logic       rx_ready_a, rx_ready_b;
    logic       perr_a, perr_b;
    logic       ferr_a, ferr_b;
    logic       ovr_a, ovr_b;
    logic       busy_a, busy_b;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int start_cyc = 0;

    logic [7:0] exp_data  [2];
    logic       exp_ready [2];
    logic       exp_ovr   [2];
    logic       exp_ferr  [2];
    logic       exp_perr  [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_fsm #(
        .WORD_LENGTH(8), .CLKS_PER_SAMPLE(CPS), .PARITY_EN(0), .PARITY_ODD(0)
    ) dut_a (
        .clk(clk), .reset(reset), .serial_in(serial_in_a), .clear_ready(clear_a),
        .rx_data(rx_data_a), .rx_ready(rx_ready_a), .parity_error(perr_a),
        .framing_error(ferr_a), .overrun(ovr_a), .busy(busy_a)
    );

    uart_rx_fsm #(
        .WORD_LENGTH(8), .CLKS_PER_SAMPLE(CPS), .PARITY_EN(1), .PARITY_ODD(0)
    ) dut_b (
        .clk(clk), .reset(reset), .serial_in(serial_in_b), .clear_ready(clear_b),
        .rx_data(rx_data_b), .rx_ready(rx_ready_b), .parity_error(perr_b),
        .framing_error(ferr_b), .overrun(ovr_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_line(input int sel, input logic v);
        if (sel == 0) serial_in_a = v;
        else          serial_in_b = v;
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            exp_data[s]  = 8'h00;
            exp_ready[s] = 1'b0;
            exp_ovr[s]   = 1'b0;
            exp_ferr[s]  = 1'b0;
            exp_perr[s]  = 1'b0;
        end
    endtask

    // Instance 1 uses even parity: the data ones plus the parity bit must be even.
    task automatic model_frame(input int sel, input logic [7:0] data,
                               input logic par, input logic stop);
        exp_ovr[sel]   = exp_ready[sel];
        exp_ready[sel] = 1'b1;
        exp_data[sel]  = data;
        exp_ferr[sel]  = !stop;
        exp_perr[sel]  = (sel == 1) ? ((($countones(data) + int'(par)) % 2) != 0) : 1'b0;
    endtask

    task automatic send_frame(input int sel, input logic [7:0] data,
                              input logic par, input logic stop);
        drive_line(sel, 1'b0);
        start_cyc = cyc;
        wait_clks(BIT);
        for (int i = 0; i < 8; i++) begin
            drive_line(sel, data[i]);
            wait_clks(BIT);
        end
        if (sel == 1) begin
            drive_line(sel, par);
            wait_clks(BIT);
        end
        drive_line(sel, stop);
        wait_clks(BIT);
        drive_line(sel, 1'b1);
        model_frame(sel, data, par, stop);
    endtask

    task automatic pulse_clear(input int sel);
        if (sel == 0) clear_a = 1'b1; else clear_b = 1'b1;
        @(negedge clk);
        if (sel == 0) clear_a = 1'b0; else clear_b = 1'b0;
        exp_ready[sel] = 1'b0;
        exp_ovr[sel]   = 1'b0;
    endtask

    task automatic check_outputs(input int sel, input string tag);
        if (sel == 0) begin
            check({tag, ".data"},  rx_data_a,  exp_data[0]);
            check({tag, ".ready"}, rx_ready_a, exp_ready[0]);
            check({tag, ".ovr"},   ovr_a,      exp_ovr[0]);
            check({tag, ".ferr"},  ferr_a,     exp_ferr[0]);
            check({tag, ".perr"},  perr_a,     exp_perr[0]);
        end else begin
            check({tag, ".data"},  rx_data_b,  exp_data[1]);
            check({tag, ".ready"}, rx_ready_b, exp_ready[1]);
            check({tag, ".ovr"},   ovr_b,      exp_ovr[1]);
            check({tag, ".ferr"},  ferr_b,     exp_ferr[1]);
            check({tag, ".perr"},  perr_b,     exp_perr[1]);
        end
    endtask

    initial begin
        int         lat;
        logic [7:0] rdata;
        logic       rstop, rpar;

        reset = 1'b0;
        serial_in_a = 1'b1; serial_in_b = 1'b1;
        clear_a = 1'b0; clear_b = 1'b0;
        model_reset();
        wait_clks(3);
        check_outputs(0, "reset_a");
        check_outputs(1, "reset_b");
        check("reset_a.busy", busy_a, 1'b0);
        check("reset_b.busy", busy_b, 1'b0);
        reset = 1'b1;
        wait_clks(20);

        // Single 8N1 frame with latency measured from the line's falling edge.
        lat = -1;
        fork
            send_frame(0, 8'hA5, 1'b0, 1'b1);
            begin
                for (int k = 0; k < 2500 && lat < 0; k++) begin
                    @(negedge clk);
                    if (rx_ready_a) lat = cyc - start_cyc;
                end
            end
        join
        check("latency_a5", lat, (lat >= 1976 && lat <= 1980) ? lat : 1978);
        check_outputs(0, "frame_a5");
        pulse_clear(0);

        // Back-to-back frames without acknowledge produce overrun.
        send_frame(0, 8'h3C, 1'b0, 1'b1);
        check_outputs(0, "b2b_3c");
        send_frame(0, 8'hC3, 1'b0, 1'b1);
        check_outputs(0, "b2b_c3");
        pulse_clear(0);
        check_outputs(0, "after_clear");

        // Short low glitch is rejected at mid start bit.
        serial_in_a = 1'b0;
        wait_clks(50);
        serial_in_a = 1'b1;
        wait_clks(10);
        check("glitch.busy_mid", busy_a, 1'b1);
        wait_clks(100);
        check("glitch.busy_end", busy_a, 1'b0);
        check_outputs(0, "glitch");

        // Stop bit low sets framing_error but still delivers the word.
        send_frame(0, 8'h55, 1'b0, 1'b0);
        check_outputs(0, "frame_err");
        wait_clks(2 * BIT);
        check("frame_err.busy", busy_a, 1'b0);

        for (int n = 0; n < 6; n++) begin
            if ($urandom_range(0, 1) == 1) pulse_clear(0);
            rdata = 8'($urandom);
            rstop = ($urandom_range(0, 3) != 0);
            send_frame(0, rdata, 1'b0, rstop);
            check_outputs(0, $sformatf("rand_a%0d", n));
            if (!rstop) wait_clks(2 * BIT);
        end

        // Even parity instance.
        send_frame(1, 8'h07, 1'b1, 1'b1);
        check_outputs(1, "par_ok");
        send_frame(1, 8'h07, 1'b0, 1'b1);
        check_outputs(1, "par_bad");
        for (int n = 0; n < 5; n++) begin
            if ($urandom_range(0, 1) == 1) pulse_clear(1);
            rdata = 8'($urandom);
            rpar  = 1'($urandom_range(0, 1));
            rstop = ($urandom_range(0, 3) != 0);
            send_frame(1, rdata, rpar, rstop);
            check_outputs(1, $sformatf("rand_b%0d", n));
            if (!rstop) wait_clks(2 * BIT);
        end

        // Reset in the middle of a 0xFF frame, then a clean frame.
        pulse_clear(0);
        serial_in_a = 1'b0;
        wait_clks(BIT);
        serial_in_a = 1'b1;
        wait_clks(3 * BIT + BIT / 2);
        reset = 1'b0;
        model_reset();
        wait_clks(2);
        check_outputs(0, "mid_reset_a");
        check_outputs(1, "mid_reset_b");
        check("mid_reset.busy", busy_a, 1'b0);
        reset = 1'b1;
        wait_clks(6 * BIT);
        check_outputs(0, "aborted");
        check("aborted.busy", busy_a, 1'b0);
        send_frame(0, 8'h81, 1'b0, 1'b1);
        check_outputs(0, "after_reset_81");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
